// File: rtl/cdc_pkg.sv
// cdc_pkg: shared FSM state type and default sizing for the CDC TX pacer
package cdc_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_GAP    = 16;
  typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/cdc_tx_pacer_if.sv
// cdc_tx_pacer_if: upstream byte handshake plus the paced CDC-side outputs
interface cdc_tx_pacer_if #(
  parameter int DATA_W = cdc_pkg::DEF_DATA_W,
  parameter int DEPTH  = cdc_pkg::DEF_DEPTH
);
  logic [DATA_W-1:0]       s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_W-1:0]       data_in_fast;
  logic                    data_valid_fast;
  logic [$clog2(DEPTH):0]  level;
  modport master (output s_data, s_valid, input s_ready, data_in_fast, data_valid_fast, level);
  modport slave (input s_data, s_valid, output s_ready, data_in_fast, data_valid_fast, level);
endinterface

// File: rtl/cdc_sync_fifo.sv
// cdc_sync_fifo: single-clock FIFO with a fall-through head and occupancy count
module cdc_sync_fifo #(
  parameter int DATA_W = cdc_pkg::DEF_DATA_W,
  parameter int DEPTH  = cdc_pkg::DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic do_push, do_pop;
  assign full  = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
  assign dout  = mem_q[rd_q];
  // Qualify requests so the count can never overflow or underflow; pointers wrap naturally
  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // Pointer and count registers; reset discards contents by emptying the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end
  // Storage needs no reset since the empty count hides stale entries
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/cdc_tx_pacer.sv
// cdc_tx_pacer: paces FIFO bytes into a toggle-based fast-to-slow CDC stage, one pulse per GAP cycles
// Optional macro CDC_PACER_STATS_EN adds a 16-bit wrapping sent_count output.
module cdc_tx_pacer
  import cdc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int GAP    = DEF_GAP
) (
  input logic           clk_fast,
  input logic           rst_n,
  cdc_tx_pacer_if.slave bus
`ifdef CDC_PACER_STATS_EN
  ,
  output logic [15:0]   sent_count
`endif
);
  localparam int CW = $clog2(GAP);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d, head;
  logic valid_q, valid_d;
  logic push, pop, full, empty;
  logic [$clog2(DEPTH):0] level;
  assign bus.s_ready         = rst_n & ~full;
  assign bus.data_in_fast    = data_q;
  assign bus.data_valid_fast = valid_q;
  assign bus.level           = level;
  assign push = bus.s_valid & bus.s_ready;
  assign pop  = (state_q == IDLE) & ~empty;
  cdc_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk_fast),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (bus.s_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );
  // State register: FSM, gap counter and the registered CDC outputs
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  // Next state: leave HOLD one cycle early so the IDLE pop lands exactly GAP cycles after the last pulse
  always_comb begin
    state_d = state_q == IDLE ? (empty ? IDLE : HOLD) : (cnt_q == '0 ? IDLE : HOLD);
  end
  // Outputs: a pop loads the byte and fires the pulse; the byte then stays put for the slow side
  always_comb begin
    valid_d = pop;
    data_d  = pop ? head : data_q;
    cnt_d   = pop ? CW'(GAP - 2) : (state_q == HOLD && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
  end
`ifdef CDC_PACER_STATS_EN
  logic [15:0] sent_count_q, sent_count_d;
  assign sent_count = sent_count_q;
  // Pulse counter, wraps naturally at 16 bits
  always_comb begin
    sent_count_d = sent_count_q + 16'(pop);
  end
  // Pulse counter register
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) sent_count_q <= '0;
    else sent_count_q <= sent_count_d;
  end
`endif
endmodule

// File: tb/tb_cdc_tx_pacer.sv
// tb_cdc_tx_pacer: directed and randomized checks of the pacer against a queue/timing reference model
module tb_cdc_tx_pacer;
  import cdc_pkg::*;
  localparam int DEPTH = DEF_DEPTH;
  localparam int GAP   = DEF_GAP;
  localparam int LW    = $clog2(DEPTH) + 1;
  logic clk_fast = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  cdc_tx_pacer_if bus ();
`ifdef CDC_PACER_STATS_EN
  logic [15:0] sent_count;
`endif
  cdc_tx_pacer dut (
    .clk_fast (clk_fast),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef CDC_PACER_STATS_EN
    ,
    .sent_count (sent_count)
`endif
  );
  always #5 clk_fast = ~clk_fast;
  always @(posedge clk_fast) cyc <= cyc + 1;

  // Reference model: a byte queue; a byte leaves at an edge when the queue was non-empty
  // before that edge and at least GAP edges have passed since the previous send.
  logic [7:0] mq[$];
  int last_p = -GAP;
  logic m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit can_push;
  always @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      last_p = cyc - GAP;
      m_valid = 1'b0;
      m_data = 8'h00;
    end else begin
      can_push = bus.s_valid && mq.size() < DEPTH;
      m_valid = mq.size() > 0 && cyc - last_p >= GAP;
      if (m_valid) begin
        m_data = mq.pop_front();
        last_p = cyc;
      end
      if (can_push) mq.push_back(bus.s_data);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk_fast);
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if (bus.data_valid_fast !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.data_valid_fast); end
    total++; if (bus.data_in_fast !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.data_in_fast); end
    total++; if (bus.level !== LW'(0)) begin bad++; $display("FAIL reset_level got=%0d want=0", bus.level); end
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.s_ready); end
    rst_n = 1'b1;
    tick();
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", bus.s_ready); end
  endtask

  task automatic test_latency();
    do_reset();
    repeat (3) tick();
    bus.s_data = 8'hA5;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    total++; if (bus.level !== LW'(1)) begin bad++; $display("FAIL lat_level1 got=%0d want=1", bus.level); end
    total++; if (bus.data_valid_fast !== 1'b0) begin bad++; $display("FAIL lat_early got=%b want=0", bus.data_valid_fast); end
    tick();
    total++; if (bus.data_valid_fast !== 1'b1) begin bad++; $display("FAIL lat_pulse got=%b want=1", bus.data_valid_fast); end
    total++; if (bus.data_in_fast !== 8'hA5) begin bad++; $display("FAIL lat_data got=%h want=a5", bus.data_in_fast); end
    total++; if (bus.level !== LW'(0)) begin bad++; $display("FAIL lat_level0 got=%0d want=0", bus.level); end
    tick();
    total++; if (bus.data_valid_fast !== 1'b0) begin bad++; $display("FAIL lat_one_cycle got=%b want=0", bus.data_valid_fast); end
    total++; if (bus.data_in_fast !== 8'hA5) begin bad++; $display("FAIL lat_hold_data got=%h want=a5", bus.data_in_fast); end
  endtask

  task automatic test_back_to_back();
    int pc[$];
    logic [7:0] pd[$];
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = 8'(i);
      tick();
      if (bus.data_valid_fast === 1'b1) begin pc.push_back(cyc); pd.push_back(bus.data_in_fast); end
    end
    total++; if (bus.level !== LW'(DEPTH)) begin bad++; $display("FAIL b2b_full_level got=%0d want=%0d", bus.level, DEPTH); end
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready got=%b want=0", bus.s_ready); end
    bus.s_data = 8'hFF;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.data_valid_fast === 1'b1) begin pc.push_back(cyc); pd.push_back(bus.data_in_fast); end
      total++; if (bus.level !== LW'(DEPTH)) begin bad++; $display("FAIL full_hold_level got=%0d want=%0d", bus.level, DEPTH); end
    end
    bus.s_valid = 1'b0;
    for (int i = 0; i < 12 * GAP && pd.size() < 9; i++) begin
      tick();
      if (bus.data_valid_fast === 1'b1) begin pc.push_back(cyc); pd.push_back(bus.data_in_fast); end
    end
    total++; if (pd.size() != 9) begin bad++; $display("FAIL b2b_count got=%0d want=9", pd.size()); end
    for (int i = 0; i < pd.size(); i++) begin
      total++; if (pd[i] !== 8'(i)) begin bad++; $display("FAIL b2b_order idx=%0d got=%h want=%h", i, pd[i], 8'(i)); end
      if (i > 0) begin
        total++; if (pc[i] - pc[i-1] != GAP) begin bad++; $display("FAIL b2b_gap idx=%0d got=%0d want=%0d", i, pc[i] - pc[i-1], GAP); end
      end
    end
    for (int i = 0; i < GAP + 4; i++) begin
      tick();
      total++; if (bus.data_valid_fast !== 1'b0) begin bad++; $display("FAIL b2b_extra_pulse data=%h want_no_pulse", bus.data_in_fast); end
    end
  endtask

  task automatic test_push_in_hold();
    bit seen = 0;
    do_reset();
    bus.s_data = 8'h20;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (bus.data_valid_fast === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL hold_first_pulse got=none want=pulse");
    end else begin
      repeat (4) tick();
      bus.s_data = 8'h10;
      bus.s_valid = 1'b1;
      for (int k = 5; k <= GAP + 1; k++) begin
        tick();
        bus.s_valid = 1'b0;
        total++; if (bus.data_valid_fast !== (k == GAP)) begin bad++; $display("FAIL hold_gap k=%0d got=%b want=%b", k, bus.data_valid_fast, k == GAP); end
        if (k == GAP) begin
          total++; if (bus.data_in_fast !== 8'h10) begin bad++; $display("FAIL hold_data got=%h want=10", bus.data_in_fast); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.s_data = 8'(8'h40 + i);
      bus.s_valid = 1'b1;
      tick();
    end
    bus.s_valid = 1'b0;
    total++; if (bus.level !== LW'(4)) begin bad++; $display("FAIL mid_level got=%0d want=4", bus.level); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.data_valid_fast !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", bus.data_valid_fast); end
    total++; if (bus.data_in_fast !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h want=00", bus.data_in_fast); end
    total++; if (bus.level !== LW'(0)) begin bad++; $display("FAIL mid_rst_level got=%0d want=0", bus.level); end
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0", bus.s_ready); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3 * GAP) begin
      tick();
      if (bus.data_valid_fast === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL mid_stale_pulses got=%0d want=0", pulses); end
    bus.s_data = 8'h3C;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    tick();
    total++; if (bus.data_valid_fast !== 1'b1) begin bad++; $display("FAIL mid_fresh_pulse got=%b want=1", bus.data_valid_fast); end
    total++; if (bus.data_in_fast !== 8'h3C) begin bad++; $display("FAIL mid_fresh_data got=%h want=3c", bus.data_in_fast); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 900; i++) begin
      if (i == 437) rst_n = 1'b0;
      if (i == 440) rst_n = 1'b1;
      bus.s_valid = ((i / 120) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      bus.s_data = 8'($urandom);
      tick();
      total++; if (bus.data_valid_fast !== m_valid) begin bad++; $display("FAIL rand_valid i=%0d got=%b want=%b", i, bus.data_valid_fast, m_valid); end
      total++; if (bus.data_in_fast !== m_data) begin bad++; $display("FAIL rand_data i=%0d got=%h want=%h", i, bus.data_in_fast, m_data); end
      total++; if (bus.level !== LW'(mq.size())) begin bad++; $display("FAIL rand_level i=%0d got=%0d want=%0d", i, bus.level, mq.size()); end
      total++; if (bus.s_ready !== (rst_n && mq.size() < DEPTH)) begin bad++; $display("FAIL rand_ready i=%0d got=%b want=%b", i, bus.s_ready, rst_n && mq.size() < DEPTH); end
    end
    bus.s_valid = 1'b0;
  endtask

`ifdef CDC_PACER_STATS_EN
  task automatic test_stats();
    do_reset();
    total++; if (sent_count !== 16'h0000) begin bad++; $display("FAIL stats_reset got=%h want=0000", sent_count); end
    force dut.sent_count_q = 16'hFFFE;
    tick();
    release dut.sent_count_q;
    for (int i = 0; i < 3; i++) begin
      bus.s_data = 8'(8'h70 + i);
      bus.s_valid = 1'b1;
      tick();
    end
    bus.s_valid = 1'b0;
    repeat (3 * GAP + 4) tick();
    total++; if (sent_count !== 16'h0001) begin bad++; $display("FAIL stats_wrap got=%h want=0001", sent_count); end
  endtask
`endif

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    test_reset();
    test_latency();
    test_back_to_back();
    test_push_in_hold();
    test_reset_mid_hold();
    test_random();
`ifdef CDC_PACER_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
